refill_read_arbiter: RTL

- Shares the single read-only cache-to-AXI4 bridge between two refill requesters: requester 0 is the I-cache and requester 1 is the D-cache.
- Each requester uses a cache-side AR/R interface: ARADDR/ARVALID/ARREADY and RDATA/RVALID/RLAST/RREADY.
- The master side connects to the bridge's cache-side ports.
- One burst is outstanding at a time. The grant is held from address acceptance until the RLAST beat handshakes. Round-robin fairness applies on ties.

---
 rtl/refill_read_arbiter_pkg.sv | 13 +
 rtl/refill_read_arbiter_rr_arbiter2.sv | 27 ++
 rtl/refill_read_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/refill_read_arbiter_pkg.sv
// Shared encodings for the refill read arbiter: FSM states and requester IDs.
package refill_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/refill_read_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen; last_grant only moves when the caller commits a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_vld,
  output logic       winner
);
  import refill_read_arbiter_pkg::*;

  logic last_grant;

  always_comb begin
    gnt_vld = |req;
    if (&req) winner = ~last_grant;
    else      winner = req[1];
  end

  // Reset to the D-cache so the I-cache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last_grant <= REQ_DCACHE;
    else if (update && gnt_vld) last_grant <= winner;
  end

endmodule

// File: rtl/refill_read_arbiter.sv
// Shares one read-only cache-to-AXI bridge between I-cache (s0) and D-cache (s1)
// refills; one burst in flight, grant held from AR accept until the RLAST beat.
module refill_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rvalid,
  output logic                  s0_rlast,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rvalid,
  output logic                  s1_rlast,
  input  logic                  s1_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready,
  output logic                  busy,
  output logic                  protocol_err
);
  import refill_read_arbiter_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN);

  state_t     state, state_nxt;
  logic       owner;
  logic [7:0] beat_cnt;
  logic       gnt_vld, winner;
  logic       accept, beat;

  // Gated by rst so no arready leaks out while reset is held.
  assign accept = (state == ST_IDLE) && gnt_vld && !rst;
  assign beat   = (state == ST_DATA) && m_rvalid && m_rready;
  assign busy   = (state != ST_IDLE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({s1_arvalid, s0_arvalid}),
    .update  (accept),
    .gnt_vld (gnt_vld),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)             state_nxt = ST_ADDR;
      ST_ADDR: if (m_arready)          state_nxt = ST_DATA;
      ST_DATA: if (beat && m_rlast)    state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        s0_arready = accept && (winner == REQ_ICACHE);
        s1_arready = accept && (winner == REQ_DCACHE);
      end
      ST_ADDR: m_arvalid = 1'b1;
      ST_DATA: begin
        m_rready  = (owner == REQ_DCACHE) ? s1_rready : s0_rready;
        s0_rvalid = m_rvalid && (owner == REQ_ICACHE);
        s1_rvalid = m_rvalid && (owner == REQ_DCACHE);
      end
      default: ;
    endcase
  end

  // Data and last are broadcast; the per-requester rvalid qualifies them.
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= REQ_ICACHE;
      beat_cnt     <= 8'd0;
      m_araddr     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        owner    <= winner;
        m_araddr <= (winner == REQ_DCACHE) ? s1_araddr : s0_araddr;
        beat_cnt <= 8'd0;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        // RLAST must land exactly on the configured final beat.
        if (m_rlast != (beat_cnt == LAST_IDX)) protocol_err <= 1'b1;
      end
    end
  end

endmodule
